// File: rtl/csa_accum_stream_if.sv
// Handshake bundle for csa_accum_stream: input beat channel, frame abort,
// and the held result channel. Widths follow the block's parameters.
interface csa_accum_stream_if #(
   parameter int W     = 8,
   parameter int LANES = 2,
   parameter int BEATS = 5
);
   localparam int OW = W + $clog2(LANES * BEATS);
   localparam int CW = $clog2(BEATS + 1);

   logic                 clear;
   logic                 in_valid;
   logic                 in_ready;
   logic [LANES*W-1:0]   in_data;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [OW-1:0]        out_sum;
   logic [CW-1:0]        out_beats;

   // Producer/consumer side (drives beats, accepts results)
   modport master (
      output clear, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_beats
   );

   // Accumulator side
   modport slave (
      input  clear, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_beats
   );
endinterface

// File: rtl/csa_accum_stream.sv
// Streaming multi-operand accumulator. Each accepted beat folds LANES
// operands into a carry-save pair (S, C) through a 3:2 compressor tree, so
// the per-beat path carries no ripple. A single carry-propagate add runs in
// a dedicated RESOLVE cycle, and the total is then held until taken.
module csa_accum_stream #(
   parameter int W     = 8,
   parameter int LANES = 2,
   parameter int BEATS = 5
) (
   input logic                clk,
   input logic                rst,
   csa_accum_stream_if.slave  bus
);
   localparam int OW = W + $clog2(LANES * BEATS);
   localparam int CW = $clog2(BEATS + 1);

   // Number of vectors still to be reduced after `lvl` compressor levels.
   function automatic int ops_at(input int lvl);
      int n;
      n = LANES + 2;
      for (int i = 0; i < lvl; i++) begin
         n = 2 * (n / 3) + n % 3;
      end
      return n;
   endfunction

   // Compressor levels needed to bring LANES+2 vectors down to two.
   function automatic int tree_depth();
      int n;
      int d;
      n = LANES + 2;
      d = 0;
      for (int i = 0; i < 64; i++) begin
         if (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            d++;
         end
      end
      return d;
   endfunction

   localparam int DEPTH = tree_depth();

   typedef enum logic [1:0] {
      ST_ACCUM   = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_OUT     = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [OW-1:0]   s_reg, s_next;
   logic [OW-1:0]   c_reg, c_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [OW-1:0]   sum_reg, sum_next;
   logic [CW-1:0]   beats_reg, beats_next;

   logic [OW-1:0]   csa_s;
   logic [OW-1:0]   csa_c;

   // Wallace-style reduction: level 0 holds the zero-extended lanes plus the
   // running S and C; each later level groups its predecessor's vectors in
   // threes through full adders and passes any leftover one or two through.
   for (genvar gi = 0; gi <= DEPTH; gi++) begin : g_lvl
      localparam int N = ops_at(gi);
      logic [N-1:0][OW-1:0] v;

      if (gi == 0) begin : g_leaf
         for (genvar gj = 0; gj < LANES; gj++) begin : g_lane
            assign v[gj] = OW'(bus.in_data[gj*W +: W]);
         end
         assign v[LANES]   = s_reg;
         assign v[LANES+1] = c_reg;
      end else begin : g_node
         localparam int P = ops_at(gi - 1);
         localparam int G = P / 3;

         for (genvar gj = 0; gj < G; gj++) begin : g_fa
            logic [OW-1:0] a, b, c;
            assign a = g_lvl[gi-1].v[3*gj];
            assign b = g_lvl[gi-1].v[3*gj+1];
            assign c = g_lvl[gi-1].v[3*gj+2];
            // Carries move one place up; the bit shifted past OW is always
            // zero because the true total fits in OW bits.
            assign v[2*gj]   = a ^ b ^ c;
            assign v[2*gj+1] = ((a & b) | (a & c) | (b & c)) << 1;
         end

         for (genvar gj = 0; gj < P % 3; gj++) begin : g_pass
            assign v[2*G+gj] = g_lvl[gi-1].v[3*G+gj];
         end
      end
   end

   assign csa_s = g_lvl[DEPTH].v[0];
   assign csa_c = g_lvl[DEPTH].v[1];

   assign bus.in_ready  = (state_reg == ST_ACCUM);
   assign bus.out_valid = (state_reg == ST_OUT);
   assign bus.out_sum   = sum_reg;
   assign bus.out_beats = beats_reg;

   // State and datapath registers; reset returns everything to idle at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_ACCUM;
         s_reg     <= '0;
         c_reg     <= '0;
         cnt_reg   <= '0;
         sum_reg   <= '0;
         beats_reg <= '0;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         c_reg     <= c_next;
         cnt_reg   <= cnt_next;
         sum_reg   <= sum_next;
         beats_reg <= beats_next;
      end
   end

   // Frame sequencing: accumulate beats, resolve once, hold the result;
   // a clear overrides whatever the current state would have done.
   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      c_next     = c_reg;
      cnt_next   = cnt_reg;
      sum_next   = sum_reg;
      beats_next = beats_reg;

      case (state_reg)
         ST_ACCUM: begin
            if (bus.in_valid) begin
               s_next   = csa_s;
               c_next   = csa_c;
               cnt_next = cnt_reg + CW'(1);
               if (bus.in_last || (cnt_reg == CW'(BEATS - 1))) begin
                  state_next = ST_RESOLVE;
               end
            end
         end
         ST_RESOLVE: begin
            sum_next   = s_reg + c_reg;
            beats_next = cnt_reg;
            state_next = ST_OUT;
         end
         ST_OUT: begin
            if (bus.out_ready) begin
               s_next     = '0;
               c_next     = '0;
               cnt_next   = '0;
               state_next = ST_ACCUM;
            end
         end
         default: begin
            state_next = ST_ACCUM;
         end
      endcase

      if (bus.clear) begin
         s_next     = '0;
         c_next     = '0;
         cnt_next   = '0;
         sum_next   = sum_reg;
         beats_next = beats_reg;
         state_next = ST_ACCUM;
      end
   end
endmodule

// File: tb/tb_csa_accum_stream.sv
// Testbench for csa_accum_stream: directed scenarios on the default
// configuration, then randomized traffic on three other configurations
// compared against a plain-arithmetic frame model.
module tb_csa_accum_stream;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   bit   rand_start;
   int   rand_done_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   csa_accum_stream_if #(.W(8), .LANES(2), .BEATS(5)) bus ();
   csa_accum_stream #(.W(8), .LANES(2), .BEATS(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- drivers (no checking) ----------------
   task automatic beat(input logic [7:0] a, input logic [7:0] b, input bit last);
      bus.in_valid = 1'b1;
      bus.in_data  = {b, a};
      bus.in_last  = last;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_out(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic take_result();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL reset_hs got ready/valid %b want 10", {bus.in_ready, bus.out_valid});
      end
      checks++;
      if (bus.out_sum !== 12'd0 || bus.out_beats !== 3'd0) begin
         errors++;
         $display("FAIL reset_out got sum %0d beats %0d want 0 0", bus.out_sum, bus.out_beats);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_frame();
      for (int k = 0; k < 5; k++) beat(8'hFF, 8'hFF, 1'b0);
      checks++;
      if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
         errors++;
         $display("FAIL full_resolve got ready/valid %b want 00", {bus.in_ready, bus.out_valid});
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_latency got valid %b ready %b want 1 0", bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.out_sum !== 12'd2550) begin
         errors++;
         $display("FAIL full_sum got %0d want 2550", bus.out_sum);
      end
      checks++;
      if (bus.out_beats !== 3'd5) begin
         errors++;
         $display("FAIL full_beats got %0d want 5", bus.out_beats);
      end
      $display("full frame sum=%0d beats=%0d", bus.out_sum, bus.out_beats);
      take_result();
      checks++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL full_release got ready/valid %b want 10", {bus.in_ready, bus.out_valid});
      end
   endtask

   task automatic test_short_frame();
      bit ok;
      beat(8'd1, 8'd2, 1'b0);
      beat(8'd3, 8'd4, 1'b1);
      wait_out(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL short_timeout got no out_valid want out_valid within 20 cycles");
      end
      checks++;
      if (bus.out_sum !== 12'd10 || bus.out_beats !== 3'd2) begin
         errors++;
         $display("FAIL short_result got sum %0d beats %0d want 10 2", bus.out_sum, bus.out_beats);
      end
      $display("short frame sum=%0d beats=%0d", bus.out_sum, bus.out_beats);
      take_result();
      for (int k = 1; k <= 5; k++) beat(8'(k), 8'(2 * k), 1'b0);
      wait_out(ok);
      checks++;
      if (!ok || bus.out_sum !== 12'd45 || bus.out_beats !== 3'd5) begin
         errors++;
         $display("FAIL k2k_result got ok %b sum %0d beats %0d want 1 45 5", ok, bus.out_sum, bus.out_beats);
      end
      $display("k/2k frame sum=%0d beats=%0d", bus.out_sum, bus.out_beats);
      take_result();
   endtask

   task automatic test_backpressure();
      bit ok;
      int exp;
      logic [7:0] a, b;
      exp = 0;
      for (int k = 0; k < 5; k++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         exp += int'(a) + int'(b);
         beat(a, b, 1'b0);
      end
      wait_out(ok);
      checks++;
      if (!ok || bus.out_sum !== 12'(exp)) begin
         errors++;
         $display("FAIL bp_sum got ok %b sum %0d want 1 %0d", ok, bus.out_sum, exp);
      end
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 16'($urandom);
         bus.in_last  = 1'($urandom);
         @(negedge clk);
         checks++;
         if ({bus.in_ready, bus.out_valid} !== 2'b01 || bus.out_sum !== 12'(exp) || bus.out_beats !== 3'd5) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got ready/valid %b sum %0d beats %0d want 01 %0d 5",
                     i, {bus.in_ready, bus.out_valid}, bus.out_sum, bus.out_beats, exp);
         end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      $display("backpressure frame sum=%0d beats=%0d", bus.out_sum, bus.out_beats);
      take_result();
      checks++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL bp_release got ready/valid %b want 10", {bus.in_ready, bus.out_valid});
      end
      beat(8'd5, 8'd6, 1'b1);
      wait_out(ok);
      checks++;
      if (!ok || bus.out_sum !== 12'd11 || bus.out_beats !== 3'd1) begin
         errors++;
         $display("FAIL bp_next got ok %b sum %0d beats %0d want 1 11 1", ok, bus.out_sum, bus.out_beats);
      end
      take_result();
   endtask

   task automatic test_clear();
      bit ok;
      beat(8'd9, 8'd9, 1'b0);
      beat(8'd9, 8'd9, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = {8'd9, 8'd9};
      bus.clear    = 1'b1;
      @(negedge clk);
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      checks++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL clear_idle got ready/valid %b want 10", {bus.in_ready, bus.out_valid});
      end
      for (int k = 0; k < 5; k++) beat(8'd7, 8'd7, 1'b0);
      wait_out(ok);
      checks++;
      if (!ok || bus.out_sum !== 12'd70 || bus.out_beats !== 3'd5) begin
         errors++;
         $display("FAIL clear_next got ok %b sum %0d beats %0d want 1 70 5", ok, bus.out_sum, bus.out_beats);
      end
      $display("post-clear frame sum=%0d beats=%0d", bus.out_sum, bus.out_beats);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      checks++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL clear_out got ready/valid %b want 10", {bus.in_ready, bus.out_valid});
      end
      beat(8'd1, 8'd1, 1'b1);
      wait_out(ok);
      checks++;
      if (!ok || bus.out_sum !== 12'd2 || bus.out_beats !== 3'd1) begin
         errors++;
         $display("FAIL clear_out_next got ok %b sum %0d beats %0d want 1 2 1", ok, bus.out_sum, bus.out_beats);
      end
      take_result();
   endtask

   task automatic test_async_reset();
      bit ok;
      beat(8'd10, 8'd20, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = {8'd30, 8'd40};
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10 || bus.out_sum !== 12'd0 || bus.out_beats !== 3'd0) begin
         errors++;
         $display("FAIL arst_accum got ready/valid %b sum %0d beats %0d want 10 0 0",
                  {bus.in_ready, bus.out_valid}, bus.out_sum, bus.out_beats);
      end
      #1 rst = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      beat(8'd3, 8'd3, 1'b0);
      beat(8'd4, 8'd4, 1'b1);
      wait_out(ok);
      checks++;
      if (!ok || bus.out_sum !== 12'd14 || bus.out_beats !== 3'd2) begin
         errors++;
         $display("FAIL arst_frame got ok %b sum %0d beats %0d want 1 14 2", ok, bus.out_sum, bus.out_beats);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10 || bus.out_sum !== 12'd0 || bus.out_beats !== 3'd0) begin
         errors++;
         $display("FAIL arst_out got ready/valid %b sum %0d beats %0d want 10 0 0",
                  {bus.in_ready, bus.out_valid}, bus.out_sum, bus.out_beats);
      end
      #1 rst = 1'b0;
      @(negedge clk);
      beat(8'd1, 8'd2, 1'b0);
      beat(8'd3, 8'd4, 1'b1);
      wait_out(ok);
      checks++;
      if (!ok || bus.out_sum !== 12'd10 || bus.out_beats !== 3'd2) begin
         errors++;
         $display("FAIL arst_after got ok %b sum %0d beats %0d want 1 10 2", ok, bus.out_sum, bus.out_beats);
      end
      take_result();
   endtask

   // ---------------- randomized configurations ----------------
   for (genvar gi = 0; gi < 3; gi++) begin : rg
      localparam int L   = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);
      localparam int B   = (gi == 1) ? 1 : 7;
      localparam int ROW = 8 + $clog2(L * B);
      localparam int RCW = $clog2(B + 1);

      csa_accum_stream_if #(.W(8), .LANES(L), .BEATS(B)) rbus ();
      csa_accum_stream #(.W(8), .LANES(L), .BEATS(B)) rdut (
         .clk (clk),
         .rst (rst),
         .bus (rbus)
      );

      initial begin : run
         int acc, n, tot, tcnt;
         bit resolving, holding, exp_ready;
         bit v, lst, ordy, clr;
         logic [L*8-1:0] d;
         rbus.clear     = 1'b0;
         rbus.in_valid  = 1'b0;
         rbus.in_data   = '0;
         rbus.in_last   = 1'b0;
         rbus.out_ready = 1'b0;
         acc = 0; n = 0; tot = 0; tcnt = 0;
         resolving = 1'b0; holding = 1'b0;
         wait (rand_start);
         for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            exp_ready = !resolving && !holding;
            checks++;
            if (rbus.in_ready !== exp_ready || rbus.out_valid !== holding) begin
               errors++;
               $display("FAIL rand%0d_hs cycle %0d got ready/valid %b%b want %b%b",
                        gi, cyc, rbus.in_ready, rbus.out_valid, exp_ready, holding);
            end
            if (holding) begin
               checks++;
               if (rbus.out_sum !== ROW'(tot) || rbus.out_beats !== RCW'(tcnt)) begin
                  errors++;
                  $display("FAIL rand%0d_result cycle %0d got sum %0d beats %0d want %0d %0d",
                           gi, cyc, rbus.out_sum, rbus.out_beats, tot, tcnt);
               end
            end
            v    = ($urandom_range(0, 3) != 0);
            lst  = ($urandom_range(0, 3) == 0);
            ordy = ($urandom_range(0, 1) == 1);
            clr  = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < L; k++) d[k*8 +: 8] = 8'($urandom);
            rbus.in_valid  = v;
            rbus.in_last   = lst;
            rbus.out_ready = ordy;
            rbus.clear     = clr;
            rbus.in_data   = d;
            // Reference: what the coming edge does to the frame in progress.
            if (clr) begin
               acc = 0; n = 0; resolving = 1'b0; holding = 1'b0;
            end else if (holding) begin
               if (ordy) begin
                  $display("rand%0d frame sum=%0d beats=%0d", gi, tot, tcnt);
                  holding = 1'b0; acc = 0; n = 0;
               end
            end else if (resolving) begin
               resolving = 1'b0; holding = 1'b1; tot = acc; tcnt = n;
            end else if (v) begin
               for (int k = 0; k < L; k++) acc += int'(d[k*8 +: 8]);
               n++;
               if (lst || n == B) resolving = 1'b1;
            end
         end
         @(negedge clk);
         rbus.in_valid  = 1'b0;
         rbus.clear     = 1'b0;
         rbus.out_ready = 1'b0;
         rand_done_cnt++;
      end
   end

   task automatic test_random();
      rand_start = 1'b1;
      for (int i = 0; i < 2000 && rand_done_cnt < 3; i++) @(negedge clk);
      checks++;
      if (rand_done_cnt != 3) begin
         errors++;
         $display("FAIL rand_timeout got %0d finished want 3", rand_done_cnt);
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rand_start    = 1'b0;
      rand_done_cnt = 0;
      rst           = 1'b1;
      bus.clear     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_full_frame();
      test_short_frame();
      test_backpressure();
      test_clear();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
